trace_capture_fifo: RTL and testbench

- Sits directly downstream of the core's debug/observation outputs: register-writeback signals plus data-memory access signals.
- Captures architectural events each cycle into a timestamped FIFO.
- Drains events over a valid/ready stream to a host-side consumer (UART bridge, bench scoreboard).
- Decouples bursty core activity from a slow drain; reports any lost events.

---
 rtl/trace_capture_fifo_if.sv | 32 +++
 rtl/trace_capture_fifo.sv | 157 +++++++++++++++
 tb/tb_trace_capture_fifo.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_fifo_if.sv
// Trace capture bus: core-side event inputs plus the drain stream.
// master = event source / stream consumer, slave = trace_capture_fifo.
interface trace_capture_fifo_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned STAMP_W = 16
);
   logic               reg_write_sig;
   logic [4:0]         reg_num;
   logic [DATA_W-1:0]  reg_data;
   logic               wr;
   logic               rd;
   logic [ADDR_W-1:0]  addr;
   logic [DATA_W-1:0]  wr_data;
   logic [DATA_W-1:0]  rd_data;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         out_kind;
   logic [ADDR_W-1:0]  out_addr;
   logic [DATA_W-1:0]  out_data;
   logic [STAMP_W-1:0] out_stamp;

   modport master (
      output reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data, out_ready,
      input  out_valid, out_kind, out_addr, out_data, out_stamp
   );

   modport slave (
      input  reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data, out_ready,
      output out_valid, out_kind, out_addr, out_data, out_stamp
   );
endinterface

// File: rtl/trace_capture_fifo.sv
// Timestamped capture FIFO for core writeback / data-memory events, drained
// over a valid/ready stream. Up to two pushes per cycle (reg event, then mem
// event). Head outputs are registered and read zero while empty.
// Optional macro TRACE_RD_CAPTURE_EN: capture mem-read events and flag wr+rd.
module trace_capture_fifo #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned STAMP_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trace_en,
   input  logic                     clear,
   trace_capture_fifo_if.slave      bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_count,
   output logic                     proto_err
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [1:0]  KIND_REG = 2'b00;
   localparam logic [1:0]  KIND_WR  = 2'b01;
   localparam logic [1:0]  KIND_RD  = 2'b10;

   typedef struct packed {
      logic [1:0]         kind;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  data;
      logic [STAMP_W-1:0] stamp;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             head_q, head_d;
   logic               valid_q, valid_d;
   logic [STAMP_W-1:0] stamp_q;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
   logic               ovf_q, ovf_d, perr_q, perr_d;
   logic [7:0]         drop_q, drop_d;

   logic               rd_en;
   logic               reg_ev, wr_ev, rd_ev, mem_ev;
   entry_t             push0, push1;
   logic [1:0]         n_ev, n_push, n_drop;
   logic               do0, do1, pop;
   logic [LVL_W-1:0]   free;
   logic [8:0]         drop_sum;

`ifdef TRACE_RD_CAPTURE_EN
   assign rd_en = bus.rd;
`else
   logic unused_rd;
   assign rd_en     = 1'b0;
   assign unused_rd = bus.rd;
`endif

   // Event extraction, space check, pointer/level/flag next-state, next head
   always_comb begin
      reg_ev    = trace_en & bus.reg_write_sig & (bus.reg_num != 5'd0);
      wr_ev     = trace_en & bus.wr;
      rd_ev     = trace_en & rd_en & ~bus.wr;
      mem_ev    = wr_ev | rd_ev;

      push1.kind  = wr_ev ? KIND_WR : KIND_RD;
      push1.addr  = bus.addr;
      push1.data  = wr_ev ? bus.wr_data : bus.rd_data;
      push1.stamp = stamp_q;

      push0.kind  = KIND_REG;
      push0.addr  = ADDR_W'(bus.reg_num);
      push0.data  = bus.reg_data;
      push0.stamp = stamp_q;
      if (!reg_ev) push0 = push1;

      // space is judged on the start-of-cycle level; a same-cycle pop frees nothing
      n_ev      = {1'b0, reg_ev} + {1'b0, mem_ev};
      free      = LVL_W'(DEPTH) - level_q;
      do0       = (n_ev != 2'd0) && (free != LVL_W'(0));
      do1       = (n_ev == 2'd2) && (free >= LVL_W'(2));
      n_push    = {1'b0, do0} + {1'b0, do1};
      n_drop    = n_ev - n_push;
      pop       = valid_q & bus.out_ready;

      level_d   = level_q + LVL_W'(n_push) - LVL_W'(pop);
      wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
      wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop);

      drop_sum  = 9'(drop_q) + 9'(n_drop);
      drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      ovf_d     = ovf_q | (n_drop != 2'd0);
      perr_d    = perr_q | (trace_en & bus.wr & rd_en);

      // next head: a slot pushed this cycle is not yet in mem_q
      valid_d   = (level_d != LVL_W'(0));
      head_d    = mem_q[rd_ptr_d];
      if (do0 && (rd_ptr_d == wr_ptr_q))  head_d = push0;
      if (do1 && (rd_ptr_d == wr_ptr_p1)) head_d = push1;
      if (!valid_d)                       head_d = '0;
   end

   // Control/status registers; reset beats clear, clear beats push/pop
   always_ff @(posedge clk) begin
      if (!reset) begin
         stamp_q  <= '0;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         perr_q   <= 1'b0;
         drop_q   <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         stamp_q <= stamp_q + STAMP_W'(1);
         if (clear) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            drop_q   <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
         end else begin
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
         end
      end
   end

   // Entry storage writes
   always_ff @(posedge clk) begin
      if (reset && !clear) begin
         if (do0) mem_q[wr_ptr_q]  <= push0;
         if (do1) mem_q[wr_ptr_p1] <= push1;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_kind  = head_q.kind;
   assign bus.out_addr  = head_q.addr;
   assign bus.out_data  = head_q.data;
   assign bus.out_stamp = head_q.stamp;
   assign level         = level_q;
   assign overflow      = ovf_q;
   assign drop_count    = drop_q;
   assign proto_err     = perr_q;
endmodule

// File: tb/tb_trace_capture_fifo.sv
// Bench for trace_capture_fifo: behavioural model + scoreboard queue, a vector
// table for short transactions and hand sequences for fill/overflow/clear/reset.
module tb_trace_capture_fifo;
   localparam int unsigned DEPTH = 16;
`ifdef TRACE_RD_CAPTURE_EN
   localparam bit RD_ON = 1'b1;
`else
   localparam bit RD_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, trace_en, clear;
   logic [4:0] level;
   logic       overflow, proto_err;
   logic [7:0] drop_count;

   always #5 clk = ~clk;

   trace_capture_fifo_if bus ();

   trace_capture_fifo dut (
      .clk        (clk),
      .reset      (reset),
      .trace_en   (trace_en),
      .clear      (clear),
      .bus        (bus),
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count),
      .proto_err  (proto_err)
   );

   typedef struct {
      logic [1:0]  kind;
      logic [8:0]  addr;
      logic [31:0] data;
      logic [15:0] stamp;
   } exp_t;

   typedef struct {
      logic        rw;
      logic [4:0]  rn;
      logic [31:0] rdat;
      logic        wr;
      logic        rd;
      logic [8:0]  addr;
      logic [31:0] wdat;
      logic [31:0] rddat;
      logic        rdy;
      int          exp_lvl;
   } vec_t;

   exp_t        sb [$];
   int          lvl_m, drop_m;
   bit          ovf_m, perr_m;
   logic [15:0] stamp_m;
   int          n_tests = 0;
   int          n_fail  = 0;
   vec_t        vt [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rw, input logic [4:0] rn, input logic [31:0] rdat,
                        input logic wr, input logic rd, input logic [8:0] addr,
                        input logic [31:0] wdat, input logic [31:0] rddat, input logic rdy);
      bus.reg_write_sig = rw;
      bus.reg_num       = rn;
      bus.reg_data      = rdat;
      bus.wr            = wr;
      bus.rd            = rd;
      bus.addr          = addr;
      bus.wr_data       = wdat;
      bus.rd_data       = rddat;
      bus.out_ready     = rdy;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, rdy);
   endtask

   // One clock: compare head at negedge, advance model at the edge
   task automatic step();
      exp_t e;
      exp_t ev [2];
      int   nev, free, pushed;
      bit   pop;
      @(negedge clk);
      check("out_valid", 64'(bus.out_valid), 64'(lvl_m != 0));
      if (lvl_m != 0) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: model holds %0d entries but scoreboard is empty", lvl_m);
         end else begin
            e = sb[0];
            check("head", 64'({bus.out_kind, bus.out_addr, bus.out_data, bus.out_stamp}),
                  64'({e.kind, e.addr, e.data, e.stamp}));
            if (bus.out_ready) void'(sb.pop_front());
         end
      end else begin
         check("head_zero", 64'({bus.out_kind, bus.out_addr, bus.out_data, bus.out_stamp}), 64'(0));
      end

      if (!reset) begin
         sb.delete();
         lvl_m = 0; drop_m = 0; ovf_m = 0; perr_m = 0; stamp_m = '0;
      end else begin
         if (clear) begin
            sb.delete();
            lvl_m = 0; drop_m = 0; ovf_m = 0; perr_m = 0;
         end else begin
            nev = 0;
            if (trace_en && bus.reg_write_sig && bus.reg_num != 5'd0) begin
               ev[nev] = '{2'b00, 9'(bus.reg_num), bus.reg_data, stamp_m};
               nev++;
            end
            if (trace_en && bus.wr) begin
               ev[nev] = '{2'b01, bus.addr, bus.wr_data, stamp_m};
               nev++;
            end else if (trace_en && RD_ON && bus.rd) begin
               ev[nev] = '{2'b10, bus.addr, bus.rd_data, stamp_m};
               nev++;
            end
            if (trace_en && RD_ON && bus.wr && bus.rd) perr_m = 1;
            free   = int'(DEPTH) - lvl_m;
            pop    = (lvl_m != 0) && bus.out_ready;
            pushed = 0;
            for (int i = 0; i < nev; i++) begin
               if (i < free) begin
                  sb.push_back(ev[i]);
                  pushed++;
               end else begin
                  drop_m = (drop_m < 255) ? drop_m + 1 : 255;
                  ovf_m  = 1;
               end
            end
            lvl_m = lvl_m + pushed - int'(pop);
         end
         stamp_m = stamp_m + 16'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      check({tag, "_level"}, 64'(level), 64'(lvl_m));
      check({tag, "_overflow"}, 64'(overflow), 64'(ovf_m));
      check({tag, "_drop"}, 64'(drop_count), 64'(drop_m));
      check({tag, "_proto"}, 64'(proto_err), 64'(perr_m));
   endtask

   initial begin
      //           rw  rn  rdat          wr  rd  addr    wdat   rddat  rdy lvl
      vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'h000, 32'h0,  32'h0,  1'b1, 1};
      vt[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0,  32'h0,  1'b1, 0};
      vt[2] = '{1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0, 9'h000, 32'h0,  32'h0,  1'b1, 0};
      vt[3] = '{1'b1, 5'd7, 32'h11,       1'b1, 1'b0, 9'h1FF, 32'h22, 32'h0,  1'b0, 2};
      vt[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0,  32'h0,  1'b1, 1};
      vt[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0,  32'h0,  1'b1, 0};
      vt[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 9'h020, 32'h0,  32'h33, 1'b1, RD_ON ? 1 : 0};
      vt[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0,  32'h0,  1'b1, 0};
      vt[8] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 9'h010, 32'h44, 32'h99, 1'b0, 1};
      vt[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 9'h000, 32'h0,  32'h0,  1'b1, 0};

      lvl_m = 0; drop_m = 0; ovf_m = 0; perr_m = 0; stamp_m = '0;
      reset = 1'b0; trace_en = 1'b0; clear = 1'b0;
      idle(1'b0);
      step(); step();
      check_status("reset");
      check("reset_valid", 64'(bus.out_valid), 64'(0));

      // stamp reaches 3 before the first table event
      reset = 1'b1; trace_en = 1'b1;
      idle(1'b1);
      step(); step(); step();

      for (int i = 0; i < 10; i++) begin
         drive(vt[i].rw, vt[i].rn, vt[i].rdat, vt[i].wr, vt[i].rd, vt[i].addr,
               vt[i].wdat, vt[i].rddat, vt[i].rdy);
         step();
         check($sformatf("vec%0d_level", i), 64'(level), 64'(vt[i].exp_lvl));
         check_status($sformatf("vec%0d", i));
      end

      // writes to x0 never captured
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 5'd0, 32'hCAFE0000 + 32'(i), 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b1);
         step();
         check("x0_level", 64'(level), 64'(0));
         check("x0_drop", 64'(drop_count), 64'(0));
      end

      // fill to DEPTH-1, then reg+mem with one free slot
      for (int i = 1; i <= 15; i++) begin
         drive(1'b1, 5'(i), 32'h0101 * 32'(i), 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
         step();
      end
      check("fill_level", 64'(level), 64'(15));
      drive(1'b1, 5'd20, 32'hA5A5, 1'b1, 1'b0, 9'h1AB, 32'h5A5A, 32'd0, 1'b0);
      step();
      check("full_level", 64'(level), 64'(16));
      check("first_drop", 64'(drop_count), 64'(1));
      check("first_ovf", 64'(overflow), 64'(1));
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 5'd3, 32'(i), 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
         step();
      end
      check("drop_sat", 64'(drop_count), 64'(255));
      check("sat_level", 64'(level), 64'(16));

      // full: same-cycle pop does not make room
      drive(1'b1, 5'd9, 32'h9999, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b1);
      step();
      check("pop_full_level", 64'(level), 64'(15));
      check_status("pop_full");

      // partial drain through the scoreboard
      idle(1'b1);
      for (int i = 0; i < 5; i++) step();
      check("drain_level", 64'(level), 64'(10));

      // clear with a live event: discarded, not counted
      clear = 1'b1;
      drive(1'b1, 5'd4, 32'h4444, 1'b1, 1'b0, 9'h044, 32'h4545, 32'd0, 1'b1);
      step();
      clear = 1'b0;
      check("clr_level", 64'(level), 64'(0));
      check("clr_ovf", 64'(overflow), 64'(0));
      check("clr_drop", 64'(drop_count), 64'(0));
      check("clr_proto", 64'(proto_err), 64'(0));
      idle(1'b1);
      step();

      // wr+rd together
      drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 9'h010, 32'h55, 32'h66, 1'b0);
      step();
      check("proto_level", 64'(level), 64'(1));
      check("proto_flag", 64'(proto_err), 64'(RD_ON));
      idle(1'b0);
      step();
      drive(1'b1, 5'd12, 32'h1212, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
      step();
      check("pre_rst_level", 64'(level), 64'(2));

      // reset mid-drain
      reset = 1'b0;
      idle(1'b1);
      step();
      check("rst_valid", 64'(bus.out_valid), 64'(0));
      check("rst_head", 64'({bus.out_kind, bus.out_addr, bus.out_data, bus.out_stamp}), 64'(0));
      check_status("rst");
      reset = 1'b1;
      drive(1'b1, 5'd31, 32'hFFFF0001, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b1);
      step();
      idle(1'b1);
      step(); step();
      check_status("end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
